if_predict_stage: RTL and testbench

Parametrised instruction-fetch stage for the rv32i pipeline. It holds the PC, drives the instruction memory, and predicts the next PC. Conditional branches use a per-PC table of saturating counters with configurable size and counter width. JAL is taken directly, and function returns (JALR) use a return-address stack (RAS). A mispredict redirect from the resolve stage overrides everything and squashes the fetched instruction.

---
 rtl/if_predict_stage_if.sv | 35 +++
 rtl/if_predict_stage.sv | 156 +++++++++++++++
 tb/tb_if_predict_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_predict_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_predict_stage_if
//  Description : Resolve-stage, instruction-memory and IF/ID signals of the
//                fetch/predict stage, grouped with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_predict_stage_if;
    logic        pipeline_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] inst_rdata;
    logic [31:0] inst_addr;
    logic        inst_read;
    logic [31:0] IR_regs_in;
    logic        predicted_branch;

    // Environment side: pipeline control, resolve feedback, memory data.
    modport master (
        output pipeline_en, redirect, redirect_pc,
        output upd_valid, upd_pc, upd_taken, inst_rdata,
        input  inst_addr, inst_read, IR_regs_in, predicted_branch
    );

    // Fetch stage side.
    modport slave (
        input  pipeline_en, redirect, redirect_pc,
        input  upd_valid, upd_pc, upd_taken, inst_rdata,
        output inst_addr, inst_read, IR_regs_in, predicted_branch
    );
endinterface
`default_nettype wire

// File: rtl/if_predict_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_predict_stage
//  Description : rv32i fetch stage with saturating-counter branch prediction,
//                direct JAL and a circular return-address stack.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_predict_stage #(
    parameter logic [31:0] RESET_PC     = 32'h00000060,
    parameter int          BHT_IDX_BITS = 5,
    parameter int          CTR_BITS     = 2,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    if_predict_stage_if.slave  bus
);

    localparam int                   c_BHT_ENTRIES = 1 << BHT_IDX_BITS;
    localparam int                   c_PTR_W       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int                   c_CNT_W       = $clog2(RAS_DEPTH + 1);
    localparam logic [CTR_BITS-1:0]  c_CTR_INIT    = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0]  c_CTR_MAX     = '1;
    localparam logic [c_PTR_W-1:0]   c_PTR_LAST    = c_PTR_W'(RAS_DEPTH - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_FULL    = c_CNT_W'(RAS_DEPTH);
    localparam logic [6:0]           c_OP_BR       = 7'b1100011;
    localparam logic [6:0]           c_OP_JAL      = 7'b1101111;
    localparam logic [6:0]           c_OP_JALR     = 7'b1100111;

    logic [31:0]              pc_q, pc_d;
    logic [CTR_BITS-1:0]      bht_q [c_BHT_ENTRIES];
    logic [31:0]              ras_q [RAS_DEPTH];
    logic [c_PTR_W-1:0]       ras_ptr_q;
    logic [c_CNT_W-1:0]       ras_cnt_q;

    logic [31:0]              w_inst;
    logic [6:0]               w_opcode;
    logic                     w_rd_link, w_rs1_link;
    logic [31:0]              w_b_imm, w_j_imm, w_pc_plus4;
    logic [BHT_IDX_BITS-1:0]  w_lookup_idx, w_upd_idx;
    logic                     w_bht_taken;
    logic [c_PTR_W-1:0]       w_ptr_next, w_ptr_prev;
    logic [31:0]              w_ras_top;
    logic                     w_ras_empty;
    logic                     w_pred, w_push, w_pop;
    logic [31:0]              w_ir;
    logic                     unused_upd_pc_bits;

    assign w_inst       = bus.inst_rdata;
    assign w_opcode     = w_inst[6:0];
    assign w_rd_link    = (w_inst[11:7] == 5'd1) || (w_inst[11:7] == 5'd5);
    assign w_rs1_link   = (w_inst[19:15] == 5'd1) || (w_inst[19:15] == 5'd5);
    assign w_b_imm      = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_j_imm      = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
    assign w_pc_plus4   = pc_q + 32'd4;

    assign w_lookup_idx = pc_q[BHT_IDX_BITS+1:2];
    assign w_upd_idx    = bus.upd_pc[BHT_IDX_BITS+1:2];
    assign w_bht_taken  = bht_q[w_lookup_idx][CTR_BITS-1];
    assign unused_upd_pc_bits = ^{bus.upd_pc[31:BHT_IDX_BITS+2], bus.upd_pc[1:0]};

    // The pointer names the next slot to write; the top entry sits just below it.
    assign w_ptr_next   = (ras_ptr_q == c_PTR_LAST) ? '0 : ras_ptr_q + c_PTR_W'(1);
    assign w_ptr_prev   = (ras_ptr_q == '0) ? c_PTR_LAST : ras_ptr_q - c_PTR_W'(1);
    assign w_ras_top    = ras_q[w_ptr_prev];
    assign w_ras_empty  = (ras_cnt_q == '0);

    always_comb begin
        pc_d   = w_pc_plus4;
        w_pred = 1'b0;
        w_ir   = bus.inst_rdata;
        w_push = 1'b0;
        w_pop  = 1'b0;
        if (bus.redirect) begin
            pc_d = bus.redirect_pc;
            w_ir = '0;
        end else begin
            case (w_opcode)
                c_OP_BR: begin
                    if (w_bht_taken) begin
                        pc_d   = pc_q + w_b_imm;
                        w_pred = 1'b1;
                    end
                end
                c_OP_JAL: begin
                    pc_d   = pc_q + w_j_imm;
                    w_push = w_rd_link;
                end
                c_OP_JALR: begin
                    // A link-register rd marks a call, which wins over return.
                    if (w_rd_link) begin
                        w_push = 1'b1;
                    end else if (w_rs1_link && !w_ras_empty) begin
                        w_pop  = 1'b1;
                        pc_d   = w_ras_top;
                        w_pred = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (bus.pipeline_en) begin
            pc_q <= pc_d;
        end
    end

    // Lookups read the registered table, so a same-index update is seen next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_BHT_ENTRIES; i++) begin
                bht_q[i] <= c_CTR_INIT;
            end
        end else if (bus.pipeline_en && bus.upd_valid) begin
            if (bus.upd_taken) begin
                if (bht_q[w_upd_idx] != c_CTR_MAX) begin
                    bht_q[w_upd_idx] <= bht_q[w_upd_idx] + CTR_BITS'(1);
                end
            end else if (bht_q[w_upd_idx] != '0) begin
                bht_q[w_upd_idx] <= bht_q[w_upd_idx] - CTR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (bus.pipeline_en) begin
            if (w_push) begin
                ras_q[ras_ptr_q] <= w_pc_plus4;
                ras_ptr_q        <= w_ptr_next;
                if (ras_cnt_q != c_CNT_FULL) begin
                    ras_cnt_q <= ras_cnt_q + c_CNT_W'(1);
                end
            end else if (w_pop) begin
                ras_ptr_q <= w_ptr_prev;
                ras_cnt_q <= ras_cnt_q - c_CNT_W'(1);
            end
        end
    end

    assign bus.inst_addr        = pc_q;
    assign bus.inst_read        = 1'b1;
    assign bus.IR_regs_in       = w_ir;
    assign bus.predicted_branch = w_pred;

endmodule
`default_nettype wire

// File: tb/tb_if_predict_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_predict_stage
//  Description : Directed vector table plus random traffic against a queue-
//                based reference model of the fetch/predict stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_predict_stage;

    localparam logic [31:0] RESET_PC  = 32'h00000060;
    localparam int          IDX_BITS  = 5;
    localparam int          CTR_BITS  = 2;
    localparam int          RAS_DEPTH = 4;
    localparam int          N_ENTRIES = 1 << IDX_BITS;
    localparam int          CTR_TOP   = (1 << CTR_BITS) - 1;
    localparam int          CTR_HALF  = 1 << (CTR_BITS - 1);

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] BEQ = 32'h00000863;  // beq x0,x0,16
    localparam logic [31:0] JAL = 32'h008000EF;  // jal x1,8
    localparam logic [31:0] RET = 32'h00008067;  // jalr x0,0(x1)

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_predict_stage_if bus ();

    if_predict_stage #(
        .RESET_PC     (RESET_PC),
        .BHT_IDX_BITS (IDX_BITS),
        .CTR_BITS     (CTR_BITS),
        .RAS_DEPTH    (RAS_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, en, redir;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] rdata;
        logic        exp_pred;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, en, redir, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] rdata, input logic pred, input logic [31:0] nxt);
        vec_t v;
        v.rst = rst; v.en = en; v.redir = redir; v.rpc = rpc;
        v.uv = uv; v.upc = upc; v.ut = ut; v.rdata = rdata;
        v.exp_pred = pred; v.exp_next = nxt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, en, redir, input logic [31:0] rpc,
                         input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] rdata);
        reset           = rst;
        bus.pipeline_en = en;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.upd_valid   = uv;
        bus.upd_pc      = upc;
        bus.upd_taken   = ut;
        bus.inst_rdata  = rdata;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    int          m_ctr [N_ENTRIES];
    logic [31:0] m_ras [$];

    function automatic bit is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC;
        for (int i = 0; i < N_ENTRIES; i++) m_ctr[i] = CTR_HALF - 1;
        m_ras.delete();
    endtask

    // act: 0 = none, 1 = push, 2 = pop
    task automatic model_eval(input logic redir, input logic [31:0] rpc, input logic [31:0] ins,
                              output logic [31:0] nxt, output logic pred,
                              output logic [31:0] ir, output int act);
        int bi, ji;
        bi   = (ins[31] ? -4096 : 0) + (ins[7] ? 2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        ji   = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + (ins[20] ? 2048 : 0)
               + int'(ins[30:21]) * 2;
        nxt  = m_pc + 32'd4;
        pred = 1'b0;
        ir   = ins;
        act  = 0;
        if (redir) begin
            nxt = rpc;
            ir  = 32'd0;
        end else if (ins[6:0] == 7'b1100011) begin
            if (m_ctr[(m_pc >> 2) % N_ENTRIES] >= CTR_HALF) begin
                nxt  = m_pc + 32'(bi);
                pred = 1'b1;
            end
        end else if (ins[6:0] == 7'b1101111) begin
            nxt = m_pc + 32'(ji);
            if (is_link(ins[11:7])) act = 1;
        end else if (ins[6:0] == 7'b1100111) begin
            if (is_link(ins[11:7])) act = 1;
            else if (is_link(ins[19:15]) && m_ras.size() > 0) begin
                act  = 2;
                nxt  = m_ras[m_ras.size() - 1];
                pred = 1'b1;
            end
        end
    endtask

    task automatic model_commit(input logic rst, en, redir, uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] nxt, input int act);
        int k;
        if (rst) begin
            model_reset();
        end else if (en) begin
            if (uv) begin
                k = (upc >> 2) % N_ENTRIES;
                m_ctr[k] = ut ? ((m_ctr[k] < CTR_TOP) ? m_ctr[k] + 1 : CTR_TOP)
                              : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
            end
            if (!redir && act == 1) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > RAS_DEPTH) m_ras.delete(0);
            end else if (!redir && act == 2) begin
                void'(m_ras.pop_back());
            end
            m_pc = nxt;
        end
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            default: return 5'd3;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: r[6:0] = 7'b1100011;
            1: begin r[6:0] = 7'b1101111; r[11:7] = pick_reg(); end
            2: begin r[6:0] = 7'b1100111; r[11:7] = pick_reg(); r[19:15] = pick_reg(); end
            3: begin r[6:0] = 7'b1100111; r[11:7] = 5'd0; r[19:15] = ($urandom_range(0, 1) != 0) ? 5'd1 : 5'd5; end
            4: r = NOP;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] e_nxt, e_ir, rpc, upc, ins;
        logic        e_pred, rst, en, redir, uv, ut;
        int          act;

        // Directed table: pc tracked per row in the trailing expected next-PC.
        add(0,1,0,0,     1,32'h60,1, BEQ, 0, 32'h64);   // lookup sees pre-update counter
        add(0,1,1,32'h60,1,32'h60,1, NOP, 0, 32'h60);
        add(0,1,0,0,     0,0,0,      BEQ, 1, 32'h70);
        for (int i = 0; i < 3; i++) add(0,1,1,32'h60,1,32'h60,1, NOP, 0, 32'h60);
        add(0,1,1,32'h60,1,32'h60,0, NOP, 0, 32'h60);   // saturated 3 -> 2
        add(0,1,0,0,     0,0,0,      BEQ, 1, 32'h70);
        add(0,1,1,32'h60,1,32'h60,0, NOP, 0, 32'h60);
        add(0,1,1,32'h60,1,32'h60,0, NOP, 0, 32'h60);
        add(0,1,0,0,     0,0,0,      BEQ, 0, 32'h64);
        add(0,1,1,32'h60,0,0,0,      NOP, 0, 32'h60);
        add(0,1,0,0,0,0,0, JAL, 0, 32'h68);
        add(0,1,0,0,0,0,0, RET, 1, 32'h64);
        add(0,1,0,0,0,0,0, JAL, 0, 32'h6C);
        add(0,1,0,0,0,0,0, JAL, 0, 32'h74);
        add(0,1,0,0,0,0,0, JAL, 0, 32'h7C);
        add(0,1,0,0,0,0,0, JAL, 0, 32'h84);
        add(0,1,0,0,0,0,0, JAL, 0, 32'h8C);
        add(0,1,0,0,0,0,0, RET, 1, 32'h88);
        add(0,1,0,0,0,0,0, RET, 1, 32'h80);
        add(0,1,0,0,0,0,0, RET, 1, 32'h78);
        add(0,1,0,0,0,0,0, RET, 1, 32'h70);
        add(0,1,0,0,0,0,0, RET, 0, 32'h74);             // oldest entry was overwritten
        add(0,1,1,32'h200,0,0,0, JAL, 0, 32'h200);
        add(0,1,0,0,0,0,0, RET, 0, 32'h204);            // redirected jal pushed nothing
        add(0,1,0,0,0,0,0, JAL, 0, 32'h20C);
        for (int i = 0; i < 3; i++) add(0,0,0,0,1,32'h20C,1, JAL, 0, 32'h20C);
        add(0,1,0,0,0,0,0, BEQ, 0, 32'h210);
        add(0,1,0,0,0,0,0, RET, 1, 32'h208);
        add(0,1,1,32'h60,1,32'h60,1, NOP, 0, 32'h60);
        add(0,1,1,32'h60,1,32'h60,1, NOP, 0, 32'h60);
        add(0,1,0,0,0,0,0, BEQ, 1, 32'h70);
        add(0,1,0,0,0,0,0, JAL, 0, 32'h78);
        add(1,1,1,32'h300,1,32'h60,1, JAL, 0, 32'h60);  // reset beats everything
        add(0,1,0,0,0,0,0, BEQ, 0, 32'h64);
        add(0,1,0,0,0,0,0, RET, 0, 32'h68);

        drive(1,0,0,0,0,0,0, NOP);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_inst_addr", bus.inst_addr, RESET_PC);
        chk("inst_read", {31'd0, bus.inst_read}, 32'd1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].en, vecs[i].redir, vecs[i].rpc,
                  vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].rdata);
            #1;
            chk($sformatf("vec%0d_pred", i), {31'd0, bus.predicted_branch}, {31'd0, vecs[i].exp_pred});
            chk($sformatf("vec%0d_ir", i), bus.IR_regs_in, vecs[i].redir ? 32'd0 : vecs[i].rdata);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_next_pc", i), bus.inst_addr, vecs[i].exp_next);
        end

        // Random traffic against the reference model.
        @(negedge clk);
        drive(1,1,0,0,0,0,0, NOP);
        @(posedge clk);
        model_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 99) < 2);
            en    = ($urandom_range(0, 99) < 85);
            redir = ($urandom_range(0, 99) < 10);
            rpc   = $urandom() & 32'hFFFF_FFFC;
            uv    = ($urandom_range(0, 99) < 40);
            upc   = ($urandom_range(0, 1) != 0) ? m_pc : (32'($urandom_range(0, 255)) << 2);
            ut    = $urandom_range(0, 1);
            ins   = rand_inst();
            drive(rst, en, redir, rpc, uv, upc, ut, ins);
            #1;
            model_eval(redir, rpc, ins, e_nxt, e_pred, e_ir, act);
            chk("rand_inst_addr", bus.inst_addr, m_pc);
            chk("rand_pred", {31'd0, bus.predicted_branch}, {31'd0, e_pred});
            chk("rand_ir", bus.IR_regs_in, e_ir);
            model_commit(rst, en, redir, uv, upc, ut, e_nxt, act);
            @(posedge clk);
        end
        #1;
        chk("rand_final_pc", bus.inst_addr, m_pc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
